// File: rtl/la_spram_pipe.sv
// la_spram_pipe: pipelined single-port RAM over tiled fakeram45-style banks with a credit-limited response FIFO.
// Define LA_SPRAM_PIPE_STATS_EN to add saturating read/write/stall counters.
module la_spram_pipe #(
   parameter int DW     = 32,
   parameter int AW     = 10,
   parameter int REGOUT = 0,
   parameter     TYPE   = "DEFAULT",
   parameter int CTRLW  = 128,
   parameter int TESTW  = 128
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [DW-1:0]    req_wmask,
   input  logic [AW-1:0]    req_addr,
   input  logic [DW-1:0]    req_din,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_dout,
   input  logic             vss,
   input  logic             vdd,
   input  logic             vddio,
   input  logic [CTRLW-1:0] ctrl,
   input  logic [TESTW-1:0] test
`ifdef LA_SPRAM_PIPE_STATS_EN
   ,
   output logic [31:0]      stat_reads,
   output logic [31:0]      stat_writes,
   output logic [31:0]      stat_stalls
`endif
);
   localparam int MD  = AW >= 9 ? 9 : AW == 8 ? 8 : AW == 7 ? 7 : 6;
   localparam int MW  = (AW >= 8 && DW >= 64) ? 64 : 32;
   localparam int NS  = (DW + MW - 1) / MW;
   localparam int PW  = NS * MW;
   localparam int BW  = AW > MD ? AW - MD : 1;
   localparam int NB  = AW > MD ? 2 ** (AW - MD) : 1;
   localparam int D   = 3 + REGOUT;
   localparam int CW  = $clog2(D + 1);
   localparam int PTW = $clog2(D);

   logic                     acc, rd_acc, push, pop, nreset_q, rd_v1_q;
   logic [BW-1:0]            bank, bsel1_q;
   logic [MD-1:0]            maddr;
   logic [PW-1:0]            wmask_p, din_p;
   logic [NB-1:0][PW-1:0]    bank_dout;
   logic [DW-1:0]            mux_d, push_d;
   logic [DW-1:0]            fifo_q [D];
   logic [CW-1:0]            cnt_q, cnt_d, fcnt_q, fcnt_d;
   logic [PTW-1:0]           wp_q, wp_d, rp_q, rp_d;
   logic                     unused_ok;

   assign acc       = req_valid && req_ready;
   assign rd_acc    = acc && !req_we;
   assign req_ready = nreset_q && cnt_q < CW'(D);
   assign maddr     = MD'(req_addr);
   assign wmask_p   = PW'(req_wmask);
   assign din_p     = PW'(req_din);
   assign rsp_valid = fcnt_q != '0;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_dout  = fifo_q[rp_q];
   assign mux_d     = bank_dout[bsel1_q][DW-1:0];
   assign unused_ok = ^{vss, vdd, vddio, ctrl, test, bank_dout, TYPE == "DEFAULT"};

   if (AW > MD) begin : g_bsel
      assign bank = req_addr[AW-1:MD];
   end else begin : g_nobsel
      assign bank = '0;
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      logic ce;
      assign ce = acc && bank == BW'(b);
      for (genvar s = 0; s < NS; s++) begin : g_slice
         logic [MW-1:0] mem_q [2**MD];
         logic [MW-1:0] dout_q, wm;
         assign wm = wmask_p[s*MW +: MW];
         always_ff @(posedge clk)
            if (ce) begin
               if (req_we) mem_q[maddr] <= (mem_q[maddr] & ~wm) | (din_p[s*MW +: MW] & wm);
               else dout_q <= mem_q[maddr];
            end
         assign bank_dout[b][s*MW +: MW] = dout_q;
      end
   end

   if (REGOUT != 0) begin : g_regout
      logic          rd_v2_q;
      logic [DW-1:0] data2_q;
      always_ff @(posedge clk) begin
         rd_v2_q <= !nreset ? 1'b0 : rd_v1_q;
         data2_q <= mux_d;
      end
      assign push   = rd_v2_q;
      assign push_d = data2_q;
   end else begin : g_direct
      assign push   = rd_v1_q;
      assign push_d = mux_d;
   end

   // Credits cover in-flight reads plus FIFO occupancy, so a push can never find the FIFO full.
   always_comb begin
      cnt_d  = cnt_q + CW'(rd_acc) - CW'(pop);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
      wp_d   = push ? (wp_q == PTW'(D - 1) ? '0 : wp_q + 1'b1) : wp_q;
      rp_d   = pop ? (rp_q == PTW'(D - 1) ? '0 : rp_q + 1'b1) : rp_q;
   end

   always_ff @(posedge clk)
      if (!nreset) begin
         cnt_q   <= '0;
         fcnt_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         rd_v1_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         rd_v1_q <= rd_acc;
      end

   always_ff @(posedge clk) begin
      nreset_q <= nreset;
      bsel1_q  <= bank;
      if (push) fifo_q[wp_q] <= push_d;
   end

   assert property (@(posedge clk) disable iff (!nreset) !(push && fcnt_q == CW'(D)));

`ifdef LA_SPRAM_PIPE_STATS_EN
   logic [31:0] reads_q, writes_q, stalls_q;
   always_ff @(posedge clk)
      if (!nreset) begin
         reads_q  <= '0;
         writes_q <= '0;
         stalls_q <= '0;
      end else begin
         if (rd_acc && !(&reads_q)) reads_q <= reads_q + 32'd1;
         if (acc && req_we && !(&writes_q)) writes_q <= writes_q + 32'd1;
         if (req_valid && !req_ready && !(&stalls_q)) stalls_q <= stalls_q + 32'd1;
      end
   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
   assign stat_stalls = stalls_q;
`endif
endmodule

// File: doc/la_spram_pipe.md
Name: la_spram_pipe

Overview:
Pipelined single-port RAM for freepdk45 built from tiled fakeram45 macros, with a valid/ready request/response interface, a credit-limited response FIFO for backpressure, and an optional extra output register stage. The bank-select used for the output mux is registered, so the mux stays aligned with the macro read latency. It sits between bus/cache controllers and the hard macros, in place of a bare combinational wrapper, wherever the consumer can stall.

Parameters:
DW, 32, data width in bits; any value ≥1, tiled in macro-width slices, unused macro bits tied 0.
AW, 10, address width; banks = max(1, 2**(AW-MD)).
REGOUT, 0, 0 or 1: adds one register stage on macro output (timing relief).
TYPE, "DEFAULT", pass-through; macro choice derived from AW/DW.
CTRLW, 128, ASIC ctrl width.
TESTW, 128, ASIC test width.

Ports:
clk  input  1  sole clock
nreset  input  1  synchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready
req_we  input  1  1=write, 0=read
req_wmask  input  DW  per-bit write mask (ignored on reads)
req_addr  input  AW  word address
req_din  input  DW  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer ready
rsp_dout  output  DW  read data
vss, vdd, vddio  input  1  power pass-through
ctrl  input  CTRLW  pass-through (unused by macro)
test  input  TESTW  pass-through (unused by macro)

Behaviour:
- Macro map: AW≥9 → 512x64 if DW≥64, else 512x32. AW=8 → 256x64/256x32 on the same DW rule. AW=7 → 128x32. Otherwise 64x32. MD is the macro address width (9/8/7/6).
- Bank = req_addr[AW-1:MD]. Only the selected bank sees ce/we. The macro address is req_addr[MD-1:0].
- Accept: acc = req_valid && req_ready. Macro ce = acc, we = acc && req_we.
- Read latency: a read accepted at rising edge T gives rsp_valid=1 from edge T+2+REGOUT, assuming the FIFO is empty and rsp_ready=1.
- Pipeline: rd_v and bank_sel are registered alongside the macro (1 cycle), plus one more stage if REGOUT=1. The output mux selects data using the registered bank_sel, never the live address. The muxed data is pushed into the FIFO when the final rd_v stage is set.
- Response FIFO: depth D = 3+REGOUT. rsp_valid = !empty. rsp_dout = head entry. Pop on rsp_valid && rsp_ready.
- Credit counter cnt, width clog2(D+1):
  - +1 on an accepted read; −1 on pop; both in the same cycle → unchanged.
  - req_ready = nreset_q && (cnt < D), registered-free combinational compare.
  - There is no rsp_ready→req_ready combinational path.
  - req_ready gates writes as well as reads; writes consume no credit.
- Throughput: back-to-back reads at 1/cycle when rsp_ready is held 1. Writes at 1/cycle always while cnt < D.
- FIFO can never overflow, because credits are bounded by D. Overflow is an assertion target.
- Write then read of the same address in consecutive cycles returns the new data (macro order).
- Reset (nreset=0 at edge): cnt=0, FIFO empty, all rd_v stages cleared.
  - rsp_valid=0 and req_ready=0 for every cycle in which nreset was sampled low; req_ready rises the first cycle after release.
  - rsp_dout is don't-care while rsp_valid=0.
  - Memory contents are not cleared.
  - Reset mid-read discards in-flight responses; no stale rsp_valid appears after release.
- rsp_dout is held stable while rsp_valid && !rsp_ready.

Optional Feature:
LA_SPRAM_PIPE_STATS_EN:
- Defined: adds outputs stat_reads[31:0], stat_writes[31:0], stat_stalls[31:0].
  - stat_reads and stat_writes count accepted reads and writes.
  - stat_stalls counts cycles with req_valid && !req_ready && nreset.
  - All three saturate at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- DW=32, AW=10 (2 banks of 512x32): write 0xDEADBEEF@0x005 and 0x12345678@0x205, then read both → rsp_dout 0xDEADBEEF then 0x12345678, each rsp_valid at T+2.
- Write 0xFFFFFFFF@0x010, then write 0x00000000 with wmask=0x0000FFFF, then read → 0xFFFF0000.
- rsp_ready=0 with 6 reads offered (REGOUT=0) → exactly 3 accepted, req_ready=0 after the third; raise rsp_ready → 3 responses in order, then the remaining 3 are accepted.
- REGOUT=1, 8 back-to-back reads with rsp_ready=1 → one accept per cycle, first rsp_valid at T+3, 8 consecutive valid cycles.
- Reset pulse 1 cycle after 2 reads are accepted → rsp_valid stays 0 after release, cnt=0, req_ready=1 the cycle after release; prior writes are still readable.
- DW=72, AW=8 (two 256x64 macros wide, upper bits tied 0): write 72'h AB_0123456789ABCDEF, read back exactly; with STATS_EN, stat_writes=1 and stat_reads=1.
